// File: rtl/decode_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// decode_sequencer_pkg
// Shared definitions for the decode sequencer slice:
//   - seq_state_e : sequencer occupancy states (EMPTY / HALF / FULL)
//   - LEN_BIT     : bit of a first instruction word that selects 32-bit length
//   - WORD_WIDTH  : width of one fetched instruction word
//   - INSTR_WIDTH : width of the widest assembled instruction
// -----------------------------------------------------------------------------
package decode_sequencer_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } seq_state_e;

    localparam int LEN_BIT     = 15;
    localparam int WORD_WIDTH  = 16;
    localparam int INSTR_WIDTH = 32;

endpackage

// File: rtl/decode_sequencer_insn_length_detect.sv
// -----------------------------------------------------------------------------
// insn_length_detect
// Combinational length classifier for a first instruction word.
// Ports:
//   word  : fetched 16-bit word
//   is_32 : 1 when the word opens a 32-bit instruction
// -----------------------------------------------------------------------------
module insn_length_detect
    import decode_sequencer_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] word,
    output logic                  is_32
);

    assign is_32 = word[LEN_BIT];

endmodule

// File: rtl/decode_sequencer.sv
// -----------------------------------------------------------------------------
// decode_sequencer
// Assembles 16-bit fetch words into 16- or 32-bit instructions for the decoder.
// Ports:
//   speedy_clock  : clock, rising edge
//   reset         : synchronous active-high reset
//   fetch_valid / fetch_word / fetch_ready : word stream from fetch
//   flush / flush_addr : drop all partial/held work, restart pointer
//   instr_valid / instr_ready / instr_word / instr_is_32 / instr_addr :
//                   assembled instruction towards the decoder
//   retired_count : number of instruction handshakes (wrapping)
// -----------------------------------------------------------------------------
module decode_sequencer
    import decode_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   speedy_clock,
    input  logic                   reset,
    input  logic                   fetch_valid,
    input  logic [WORD_WIDTH-1:0]  fetch_word,
    output logic                   fetch_ready,
    input  logic                   flush,
    input  logic [ADDR_WIDTH-1:0]  flush_addr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_word,
    output logic                   instr_is_32,
    output logic [ADDR_WIDTH-1:0]  instr_addr,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    localparam logic [1:0] ST_EMPTY = EMPTY;
    localparam logic [1:0] ST_HALF  = HALF;
    localparam logic [1:0] ST_FULL  = FULL;

    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]             state_r;
    logic [1:0]             state_s;
    logic [WORD_WIDTH-1:0]  first_word_r;
    logic [WORD_WIDTH-1:0]  first_word_s;
    logic [ADDR_WIDTH-1:0]  first_addr_r;
    logic [ADDR_WIDTH-1:0]  first_addr_s;
    logic [ADDR_WIDTH-1:0]  ptr_r;
    logic [ADDR_WIDTH-1:0]  ptr_s;
    logic [INSTR_WIDTH-1:0] instr_word_r;
    logic                   instr_is_32_r;
    logic [ADDR_WIDTH-1:0]  instr_addr_r;
    logic [COUNT_WIDTH-1:0] retired_count_r;
    logic [COUNT_WIDTH-1:0] retired_count_s;

    logic                   is_32_s;
    logic                   accept_s;
    logic                   consume_s;
    logic                   load_s;
    logic [INSTR_WIDTH-1:0] load_word_s;
    logic                   load_is_32_s;
    logic [ADDR_WIDTH-1:0]  load_addr_s;

    insn_length_detect u_len (
        .word  (fetch_word),
        .is_32 (is_32_s)
    );

    // In FULL the ready is a pass-through of instr_ready so a consume and a
    // new word can share one cycle; reset and flush always block fetch.
    assign fetch_ready = !reset && !flush &&
                         ((state_r != ST_FULL) || instr_ready);
    assign instr_valid = (state_r == ST_FULL);
    assign accept_s    = fetch_valid && fetch_ready;
    assign consume_s   = instr_valid && instr_ready;

    assign instr_word    = instr_word_r;
    assign instr_is_32   = instr_is_32_r;
    assign instr_addr    = instr_addr_r;
    assign retired_count = retired_count_r;

    // Next-state, pointer and output-load decisions for the handshake path.
    always_comb begin
        state_s         = state_r;
        ptr_s           = ptr_r;
        first_word_s    = first_word_r;
        first_addr_s    = first_addr_r;
        load_s          = 1'b0;
        load_word_s     = instr_word_r;
        load_is_32_s    = instr_is_32_r;
        load_addr_s     = instr_addr_r;
        if (consume_s) begin
            retired_count_s = retired_count_r + COUNT_ONE;
        end else begin
            retired_count_s = retired_count_r;
        end

        case (state_r)
            ST_EMPTY, ST_FULL: begin
                // FULL behaves like EMPTY once its instruction is consumed.
                if ((state_r == ST_EMPTY) || consume_s) begin
                    if (accept_s) begin
                        ptr_s = ptr_r + ADDR_ONE;
                        if (is_32_s) begin
                            first_word_s = fetch_word;
                            first_addr_s = ptr_r;
                            state_s      = ST_HALF;
                        end else begin
                            load_s       = 1'b1;
                            load_word_s  = {16'h0000, fetch_word};
                            load_is_32_s = 1'b0;
                            load_addr_s  = ptr_r;
                            state_s      = ST_FULL;
                        end
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end else begin
                    state_s = ST_FULL;
                end
            end
            ST_HALF: begin
                // Second word: its length bit carries no meaning.
                if (accept_s) begin
                    ptr_s        = ptr_r + ADDR_ONE;
                    load_s       = 1'b1;
                    load_word_s  = {first_word_r, fetch_word};
                    load_is_32_s = 1'b1;
                    load_addr_s  = first_addr_r;
                    state_s      = ST_FULL;
                end else begin
                    state_s = ST_HALF;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
    end

    // State, pointer, counter and instruction registers with reset > flush > handshake.
    always_ff @(posedge speedy_clock) begin
        if (reset) begin
            state_r         <= ST_EMPTY;
            ptr_r           <= '0;
            first_word_r    <= '0;
            first_addr_r    <= '0;
            instr_word_r    <= '0;
            instr_is_32_r   <= 1'b0;
            instr_addr_r    <= '0;
            retired_count_r <= '0;
        end else if (flush) begin
            // Held outputs stay as they are; only the valid (state) drops.
            state_r <= ST_EMPTY;
            ptr_r   <= flush_addr;
        end else begin
            state_r         <= state_s;
            ptr_r           <= ptr_s;
            first_word_r    <= first_word_s;
            first_addr_r    <= first_addr_s;
            retired_count_r <= retired_count_s;
            if (load_s) begin
                instr_word_r  <= load_word_s;
                instr_is_32_r <= load_is_32_s;
                instr_addr_r  <= load_addr_s;
            end else begin
                instr_word_r  <= instr_word_r;
                instr_is_32_r <= instr_is_32_r;
                instr_addr_r  <= instr_addr_r;
            end
        end
    end

endmodule

// File: tb/tb_decode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_decode_sequencer
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a word-queue model.
// -----------------------------------------------------------------------------
module tb_decode_sequencer;

    logic        speedy_clock = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [15:0] fetch_word;
    logic        fetch_ready;
    logic        flush;
    logic [15:0] flush_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;
    logic        instr_is_32;
    logic [15:0] instr_addr;
    logic [15:0] retired_count;

    int checks = 0;
    int fails  = 0;

    // Model: accepted-but-unassembled words and the currently offered instruction.
    logic [15:0] pend_w[$];
    logic [15:0] pend_a[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_word  = 32'h0;
    logic        m_is32  = 1'b0;
    logic [15:0] m_addr  = 16'h0;
    logic [15:0] m_ptr   = 16'h0;
    logic [15:0] m_cnt   = 16'h0;

    always #5 speedy_clock = ~speedy_clock;

    decode_sequencer #(.ADDR_WIDTH(16), .COUNT_WIDTH(16)) dut (
        .speedy_clock  (speedy_clock),
        .reset         (reset),
        .fetch_valid   (fetch_valid),
        .fetch_word    (fetch_word),
        .fetch_ready   (fetch_ready),
        .flush         (flush),
        .flush_addr    (flush_addr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_word    (instr_word),
        .instr_is_32   (instr_is_32),
        .instr_addr    (instr_addr),
        .retired_count (retired_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model
    // at the rising edge, return just after it.
    task automatic cycle(input logic rst, input logic fv, input logic [15:0] fw,
                         input logic fl, input logic [15:0] fa, input logic ir);
        logic exp_fr;
        reset       = rst;
        fetch_valid = fv;
        fetch_word  = fw;
        flush       = fl;
        flush_addr  = fa;
        instr_ready = ir;
        exp_fr = !rst && !fl && !(m_valid && !ir);
        @(negedge speedy_clock);
        check("fetch_ready",   {31'h0, fetch_ready}, {31'h0, exp_fr});
        check("instr_valid",   {31'h0, instr_valid}, {31'h0, m_valid});
        check("instr_word",    instr_word, m_word);
        check("instr_is_32",   {31'h0, instr_is_32}, {31'h0, m_is32});
        check("instr_addr",    {16'h0, instr_addr}, {16'h0, m_addr});
        check("retired_count", {16'h0, retired_count}, {16'h0, m_cnt});
        @(posedge speedy_clock);
        if (rst) begin
            pend_w.delete(); pend_a.delete();
            m_valid = 1'b0; m_word = 32'h0; m_is32 = 1'b0;
            m_addr = 16'h0; m_ptr = 16'h0; m_cnt = 16'h0;
        end else if (fl) begin
            pend_w.delete(); pend_a.delete();
            m_valid = 1'b0;
            m_ptr   = fa;
        end else begin
            if (m_valid && ir) begin
                m_cnt++;
                m_valid = 1'b0;
            end
            if (fv && exp_fr) begin
                pend_w.push_back(fw);
                pend_a.push_back(m_ptr);
                m_ptr++;
                if (!pend_w[0][15]) begin
                    m_word = {16'h0000, pend_w[0]}; m_is32 = 1'b0;
                    m_addr = pend_a[0]; m_valid = 1'b1;
                    pend_w.delete(); pend_a.delete();
                end else if (pend_w.size() == 2) begin
                    m_word = {pend_w[0], pend_w[1]}; m_is32 = 1'b1;
                    m_addr = pend_a[0]; m_valid = 1'b1;
                    pend_w.delete(); pend_a.delete();
                end
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; fetch_valid = 1'b0; fetch_word = 16'h0; flush = 1'b0;
        flush_addr = 16'h0; instr_ready = 1'b0;
        repeat (2) @(posedge speedy_clock);
        #1;
        cycle(1'b1, 1'b1, 16'h1234, 1'b1, 16'h5555, 1'b1);

        // Reset state, pinned literally.
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_word",  instr_word, 32'h0);
        check("rst_count", {16'h0, retired_count}, 32'h0);

        // Single 16-bit word.
        cycle(1'b0, 1'b1, 16'h0123, 1'b0, 16'h0, 1'b0);
        check("s16_valid", {31'h0, instr_valid}, 32'h1);
        check("s16_word",  instr_word, 32'h0000_0123);
        check("s16_is32",  {31'h0, instr_is_32}, 32'h0);
        check("s16_addr",  {16'h0, instr_addr}, 32'h0);

        // 32-bit pair with the second word's bit 15 clear.
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 1'b1, 16'h8A01, 1'b0, 16'h0, 1'b1);
        check("s32_half_valid", {31'h0, instr_valid}, 32'h0);
        cycle(1'b0, 1'b1, 16'h7FFF, 1'b0, 16'h0, 1'b1);
        check("s32_word", instr_word, 32'h8A01_7FFF);
        check("s32_is32", {31'h0, instr_is_32}, 32'h1);
        check("s32_addr", {16'h0, instr_addr}, 32'h0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        check("s32_count", {16'h0, retired_count}, 32'h1);

        // Back-to-back 16-bit words, one instruction per cycle.
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 16'h0010 + 16'(i), 1'b0, 16'h0, 1'b1);
            check("b2b_valid", {31'h0, instr_valid}, 32'h1);
            check("b2b_addr",  {16'h0, instr_addr}, i);
        end

        // Stall in FULL, then release loads the waiting word the same cycle.
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0011, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 16'h0022, 1'b0, 16'h0, 1'b0);
            check("stall_word", instr_word, 32'h0000_0011);
        end
        cycle(1'b0, 1'b1, 16'h0022, 1'b0, 16'h0, 1'b1);
        check("release_word",  instr_word, 32'h0000_0022);
        check("release_count", {16'h0, retired_count}, 32'h1);

        // Flush while half an instruction is latched.
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 1'b1, 16'h8000, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 1'b1, 16'h1111, 1'b1, 16'h0040, 1'b0);
        check("flush_valid", {31'h0, instr_valid}, 32'h0);
        cycle(1'b0, 1'b1, 16'h0005, 1'b0, 16'h0, 1'b0);
        check("flush_word", instr_word, 32'h0000_0005);
        check("flush_addr", {16'h0, instr_addr}, 32'h0040);

        // Pointer wrap across a 32-bit pair.
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'hFFFF, 1'b0);
        cycle(1'b0, 1'b1, 16'h8001, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0002, 1'b0, 16'h0, 1'b0);
        check("wrap_addr0", {16'h0, instr_addr}, 32'hFFFF);
        cycle(1'b0, 1'b1, 16'h0003, 1'b0, 16'h0, 1'b1);
        check("wrap_addr1", {16'h0, instr_addr}, 32'h0001);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                  16'($urandom), $urandom_range(0, 31) == 0,
                  16'($urandom), $urandom_range(0, 2) != 0);
        end

        // Retired counter wrap: 65536 cycles of 16-bit traffic -> 65535 consumes.
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 65536; i++) begin
            cycle(1'b0, 1'b1, 16'h0001, 1'b0, 16'h0, 1'b1);
        end
        check("count_max", {16'h0, retired_count}, 32'hFFFF);
        cycle(1'b0, 1'b1, 16'h0001, 1'b0, 16'h0, 1'b1);
        check("count_wrap", {16'h0, retired_count}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
